// File: rtl/tx_feed_queue.sv
// tx_feed_queue: FIFO feeder for the serial transmitter (dclk_tx_bram).
// Buffers WIDTH-bit producer items and hands them to the transmitter one
// at a time through the req / parallel_out handshake, pacing on tx_busy.
// Optional build macro TX_FEED_TIMEOUT_EN: re-pulses req when tx_busy does
// not rise within ACK_TIMEOUT cycles and flags it on timeout_err. Without the
// macro, ACK waits indefinitely and timeout_err is tied low.
module tx_feed_queue #(
    parameter int unsigned WIDTH       = 40,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [WIDTH-1:0]       item_in,
    input  logic                   item_wr,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   tx_busy,
    output logic                   req,
    output logic [WIDTH-1:0]       parallel_out,
    output logic                   timeout_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_BUSY,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [WIDTH-1:0]   pout_q, pout_d;
    logic               push;
    logic               pop;

    // full is taken from the registered count, so a same-cycle pop never
    // makes room for a push into a full FIFO.
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(DEPTH - 1));
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign parallel_out = pout_q;
    assign req         = (state_q == S_REQ);

    assign push = item_wr && !full;
    assign pop  = (state_q == S_IDLE) && en && (count_q != '0) && !tx_busy;

`ifdef TX_FEED_TIMEOUT_EN
    localparam int unsigned TMO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_err_q, tmo_err_d;
    logic             tmo_hit;

    // ACK lasts TMO_LAST+1 cycles before a retry, giving a req period of ACK_TIMEOUT+2.
    assign tmo_hit     = (state_q == S_ACK) && !tx_busy && (tmo_q == TMO_LAST);
    assign timeout_err = tmo_err_q;

    // Timeout counter runs only while waiting for tx_busy in ACK.
    always_comb begin
        tmo_d     = '0;
        tmo_err_d = tmo_err_q;
        if (state_q == S_ACK && !tx_busy) begin
            if (tmo_hit) begin
                tmo_d     = '0;
                tmo_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Timeout counter and sticky error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // Transfer FSM next state and gap counter.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                if (tx_busy) begin
                    state_d = S_BUSY;
                end
`ifdef TX_FEED_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = S_REQ;
                end
`endif
            end
            S_BUSY: begin
                if (!tx_busy) begin
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers, occupancy, overflow flag and output holding register.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pout_d     = pout_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (item_wr && full) overflow_d = 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            pout_d   = mem[rd_ptr_q];
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= item_in;
    end

    // Control and output registers; reset drops any in-flight transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            pout_q     <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            pout_q     <= pout_d;
        end
    end

endmodule
